sha256_msg_sched: RTL

Message-schedule stage for the SHA256 core.
- Accepts one 512-bit block as 16 streamed 32-bit words.
- Then produces W[t] for t = 0..63, one word per round step.
- Its step input is driven in lockstep with the 6-bit round counter enable, so W[t] is aligned with round index t for the compression stage downstream.
- Holds a 16-word sliding window and computes W[t+16] on the fly.

---
 rtl/sha256_pkg.sv | 39 +++
 rtl/sha256_msg_sched.sv | 96 +++++++++
 2 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types and bit-mixing functions used by the message
// schedule and the compression stage.
package sha256_pkg;

   localparam int WORD_W     = 32;
   localparam int NUM_ROUNDS = 64;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [5:0]        round_t;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN
   } sched_state_t;

   function automatic word_t rotr(input word_t x, input int unsigned n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   // Lower-case sigmas feed the message schedule.
   function automatic word_t sig0(input word_t x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic word_t sig1(input word_t x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Upper-case Sigmas feed the compression rounds.
   function automatic word_t big_sig0(input word_t x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic word_t big_sig1(input word_t x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads 16 words, then emits W[0..63] one per step
// from a 16-word sliding window, computing W[t+16] as the window advances.
module sha256_msg_sched
   import sha256_pkg::*;
#(
   parameter int WORD_W     = 32,
   parameter int NUM_ROUNDS = sha256_pkg::NUM_ROUNDS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_word,
   input  logic              step,
   output logic              w_valid,
   output logic [WORD_W-1:0] w_t,
   output logic [5:0]        rnd,
   output logic              done
);

   sched_state_t state_q, state_d;
   word_t        win_q [16];
   word_t        win_d [16];
   logic [3:0]   cnt_q, cnt_d;
   round_t       rnd_q, rnd_d;
   logic         done_q, done_d;
   logic         accept;
   logic         last_round;
   word_t        next_w;

   assign in_ready   = (state_q != RUN);
   assign accept     = in_valid && in_ready;
   assign last_round = (rnd_q == round_t'(NUM_ROUNDS - 1));
   assign next_w     = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

   always_comb begin
      // NOTE: every _d gets a default before the case, so no path can leave one unassigned and infer a latch.
      state_d = state_q;
      win_d   = win_q;
      cnt_d   = cnt_q;
      rnd_d   = rnd_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE, LOAD: begin
            if (accept) begin
               for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
               win_d[15] = in_word;
               cnt_d     = cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  state_d = RUN;
                  rnd_d   = '0;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         RUN: begin
            if (step) begin
               for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
               win_d[15] = next_w;
               rnd_d     = rnd_q + 6'd1;
               if (last_round) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rnd_q   <= '0;
         done_q  <= 1'b0;
         // NOTE: the window is 16 plain flops, not a RAM, and is cleared so w_t reads 0 straight out of reset.
         for (int i = 0; i < 16; i++) win_q[i] <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values and the window shift cannot ripple.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rnd_q   <= rnd_d;
         done_q  <= done_d;
         win_q   <= win_d;
      end
   end

   assign w_valid = (state_q == RUN);
   assign w_t     = (state_q == RUN) ? win_q[0] : '0;
   assign rnd     = rnd_q;
   assign done    = done_q;

endmodule
